// File: rtl/caja_musical_pkg.sv
// caja_musical_pkg -- shared types and constants for the music-box melody
// sequencer: FSM state encoding, ROM word layout and the note-to-divisor table.
// Divisors assume a 12 MHz system clock: divisor = 12_000_000 / (2 * f_note).
package caja_musical_pkg;

  localparam int NOTA_W  = 5;   // note index field of a ROM word
  localparam int DUR_W   = 3;   // duration field of a ROM word, in tempo units
  localparam int FREQ_W  = 16;  // half-period divisor width
  localparam int DUR_MAX = 7;   // largest duration a ROM word can encode

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } estado_t;

  // One melody step; dur == 0 marks the end of the melody.
  typedef struct packed {
    logic [NOTA_W-1:0] nota;
    logic [DUR_W-1:0]  dur;
  } paso_t;

  // Chromatic scale C4 (index 1) to B5 (index 24); index 0 is a rest and
  // indices 25..31 are unused, both silent.
  localparam logic [FREQ_W-1:0] TABLA_DIVISOR [32] = '{
    16'd0,
    16'd22933, 16'd21646, 16'd20431, 16'd19284, 16'd18202, 16'd17180,
    16'd16216, 16'd15306, 16'd14447, 16'd13636, 16'd12871, 16'd12148,
    16'd11466, 16'd10823, 16'd10215, 16'd9642,  16'd9101,  16'd8590,
    16'd8108,  16'd7653,  16'd7223,  16'd6818,  16'd6435,  16'd6074,
    16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0
  };

  function automatic logic [FREQ_W-1:0] divisor_de_nota(input logic [NOTA_W-1:0] nota);
    return TABLA_DIVISOR[nota];
  endfunction

endpackage

// File: rtl/rom_melodia.sv
// rom_melodia -- registered melody ROM. The word for the address presented in
// one cycle is available on paso_o in the next cycle.
module rom_melodia
  import caja_musical_pkg::*;
#(
  parameter int N_PASOS = 32,
  parameter int ADDR_W  = (N_PASOS > 1) ? $clog2(N_PASOS) : 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output paso_t             paso_o
);

  paso_t paso_d;
  paso_t paso_q;

  // Melody contents: A4 for two units, a one-unit rest, B4 for one unit, end.
  always_comb begin
    paso_d = '0;  // every address not listed holds an end marker
    case (int'(addr_i))
      0:       paso_d = '{nota: NOTA_W'(10), dur: DUR_W'(2)};
      1:       paso_d = '{nota: NOTA_W'(0),  dur: DUR_W'(1)};
      2:       paso_d = '{nota: NOTA_W'(12), dur: DUR_W'(1)};
      default: paso_d = '0;
    endcase
  end

  // Read register giving the one-cycle ROM latency.
  // NOTE: the ROM read register has no reset; its contents are only consumed
  // in LOAD, which always follows a cycle in which a valid address was presented.
  always_ff @(posedge clk) begin
    paso_q <= paso_d;
  end

  assign paso_o = paso_q;

endmodule

// File: rtl/secuenciador_melodia.sv
// secuenciador_melodia -- steps through the melody ROM and drives a tone
// generator with a note index, a half-period divisor and a gate.
// Optional feature: define SECUENCIADOR_GAP_EN to build the silent articulation
// (GAP) at the end of each note slot; without it notes are played legato.
// Either way a slot lasts 1 + dur*TEMPO_TICKS cycles from LOAD to next LOAD.
module secuenciador_melodia
  import caja_musical_pkg::*;
#(
  parameter int TEMPO_TICKS = 1_500_000,
  parameter int GAP_TICKS   = 120_000,
  parameter int N_PASOS     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [NOTA_W-1:0] indice_nota,
  output logic [FREQ_W-1:0] freq,
  output logic              sonando,
  output logic              busy,
  output logic              fin
);

  localparam int ADDR_W = (N_PASOS > 1) ? $clog2(N_PASOS) : 1;
  localparam int CNT_W  = $clog2(DUR_MAX * TEMPO_TICKS + 1);

`ifdef SECUENCIADOR_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  // Silent tail of every slot; zero when notes run legato.
  localparam int GAP_LEN = GAP_EN ? GAP_TICKS : 0;

  localparam logic [CNT_W-1:0]  TEMPO_C  = CNT_W'(TEMPO_TICKS);
  localparam logic [CNT_W-1:0]  GAP_C    = CNT_W'(GAP_LEN);
  localparam logic [ADDR_W-1:0] ADDR_ULT = ADDR_W'(N_PASOS - 1);

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [NOTA_W-1:0] nota_q,  nota_d;
  logic [FREQ_W-1:0] freq_q,  freq_d;

  paso_t             paso;
  logic [ADDR_W-1:0] addr_sig;

  // The ROM is addressed with next-state addr so the word for addr_q is
  // already registered by the time LOAD looks at it.
  rom_melodia #(
    .N_PASOS (N_PASOS),
    .ADDR_W  (ADDR_W)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_d),
    .paso_o (paso)
  );

  // Following step; running off the end of the ROM restarts at step 0.
  assign addr_sig = (addr_q == ADDR_ULT) ? '0 : addr_q + ADDR_W'(1);

  // State and datapath registers; rst outranks every other input.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      nota_q  <= '0;
      freq_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      nota_q  <= nota_d;
      freq_q  <= freq_d;
    end
  end

  // Next-state logic: stop aborts from anywhere, start only counts in IDLE.
  // NOTE: every signal gets a hold value before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    nota_d  = nota_q;
    freq_d  = freq_q;
    if (stop) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      nota_d  = '0;
      freq_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
            addr_d  = '0;
          end
        end
        ST_LOAD: begin
          if (paso.dur == '0) begin
            if (loop_en) begin
              state_d = ST_LOAD;
              addr_d  = '0;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_PLAY;
            nota_d  = paso.nota;
            freq_d  = divisor_de_nota(paso.nota);
            // Counts down to 0 over the sounding part of the slot.
            cnt_d   = CNT_W'(paso.dur) * TEMPO_C - GAP_C - CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (cnt_q == '0) begin
`ifdef SECUENCIADOR_GAP_EN
            state_d = ST_GAP;
            cnt_d   = GAP_C - CNT_W'(1);
`else
            state_d = ST_LOAD;
            addr_d  = addr_sig;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`ifdef SECUENCIADOR_GAP_EN
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_LOAD;
            addr_d  = addr_sig;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`endif
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: tone only while PLAY holds a real note, the index through the
  // whole note (PLAY and GAP), fin for the single DONE cycle.
  always_comb begin
    indice_nota = '0;
    freq        = '0;
    sonando     = 1'b0;
    busy        = (state_q != ST_IDLE);
    fin         = 1'b0;
    unique case (state_q)
      ST_PLAY: begin
        indice_nota = nota_q;
        freq        = freq_q;
        sonando     = (nota_q != '0);
      end
`ifdef SECUENCIADOR_GAP_EN
      ST_GAP:  indice_nota = nota_q;
`endif
      ST_DONE: fin = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_secuenciador_melodia.sv
// Bench for secuenciador_melodia with TEMPO_TICKS=10, GAP_TICKS=2 and the
// melody {A4,2},{rest,1},{B4,1},{end}. Works in both builds: with
// SECUENCIADOR_GAP_EN each slot ends in 2 silent cycles, without it notes are legato.
module tb_secuenciador_melodia;

  localparam int T  = 10;
  localparam int GP = 2;
  localparam int NP = 32;
`ifdef SECUENCIADOR_GAP_EN
  localparam int G = GP;
`else
  localparam int G = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en;
  logic [4:0]  indice_nota;
  logic [15:0] freq;
  logic        sonando, busy, fin;

  always #5 clk = ~clk;

  secuenciador_melodia #(
    .TEMPO_TICKS (T),
    .GAP_TICKS   (GP),
    .N_PASOS     (NP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .indice_nota (indice_nota),
    .freq        (freq),
    .sonando     (sonando),
    .busy        (busy),
    .fin         (fin)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model: expected-output timeline ----------------
  typedef struct {
    int idx;
    int frq;
    bit son;
    bit bsy;
    bit fn;
  } esp_t;

  esp_t q[$];         // expected outputs, one entry per cycle still to come
  bit   model_cont;   // melody restarts when the current pass is used up
  bit   cmp_en = 1'b0;

  int mel_nota [4] = '{10, 0, 12, 0};
  int mel_dur  [4] = '{2, 1, 1, 0};

  // Divisor from the musical frequency of the note.
  function automatic int divisor(input int n);
    real f;
    case (n)
      10:      f = 440.0;
      12:      f = 493.883;
      default: return 0;
    endcase
    return int'($floor(12_000_000.0 / (2.0 * f)));
  endfunction

  function automatic void push(input int idx, input int frq, input bit son, input bit fn, input int n);
    esp_t e;
    e.idx = idx; e.frq = frq; e.son = son; e.bsy = 1'b1; e.fn = fn;
    for (int i = 0; i < n; i++) q.push_back(e);
  endfunction

  // Appends one pass over the melody; returns 1 if playback continues after it.
  function automatic bit append_pass(input bit lp);
    for (int s = 0; s < NP; s++) begin
      int n;
      int d;
      n = (s < 4) ? mel_nota[s] : 0;
      d = (s < 4) ? mel_dur[s]  : 0;
      if (d == 0) begin
        push(0, 0, 1'b0, 1'b0, 1);           // slot start that finds the end marker
        if (lp) return 1'b1;
        push(0, 0, 1'b0, 1'b1, 1);           // completion pulse
        return 1'b0;
      end
      push(0, 0, 1'b0, 1'b0, 1);             // slot start
      push(n, divisor(n), n != 0, 1'b0, d * T - G);
      push(n, 0, 1'b0, 1'b0, G);
    end
    return 1'b1;
  endfunction

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (rst || stop) begin
      q.delete();
      model_cont <= 1'b0;
    end else if (q.size() == 0) begin
      if (start) model_cont <= append_pass(loop_en);
    end else begin
      void'(q.pop_front());
      if (q.size() == 0 && model_cont) model_cont <= append_pass(loop_en);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : cmp
    esp_t e;
    if (cmp_en) begin
      if (q.size() > 0) e = q[0];
      else begin
        e.idx = 0; e.frq = 0; e.son = 1'b0; e.bsy = 1'b0; e.fn = 1'b0;
      end
      check("cycle {idx,freq,son,busy,fin}",
            int'({indice_nota, freq, sonando, busy, fin}),
            int'({e.idx[4:0], e.frq[15:0], e.son, e.bsy, e.fn}));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  int k, a4, a4_son, b4, fin_n, k_fin, k_idle, f2, onsets, busy_low, prev_f;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    tick();
    check("rst_indice_nota", int'(indice_nota), 0);
    check("rst_freq",        int'(freq),        0);
    check("rst_sonando",     int'(sonando),     0);
    check("rst_busy",        int'(busy),        0);
    check("rst_fin",         int'(fin),         0);
    rst = 1'b0;
    tick();

    // Full melody, no loop; an extra start mid-note must be ignored.
    start = 1'b1; tick(); start = 1'b0;
    k = 1; a4 = 0; a4_son = 0; b4 = 0; fin_n = 0; k_fin = 0; k_idle = 0; f2 = 0;
    while (k < 200 && k_idle == 0) begin
      if (indice_nota == 5'd10) a4++;
      if (indice_nota == 5'd10 && sonando) a4_son++;
      if (k == 2) f2 = int'(freq);
      if (freq == 16'd12148) b4++;
      if (fin) begin fin_n++; k_fin = k; end
      if (k_fin != 0 && !busy) k_idle = k;
      start = (k == 10);
      tick();
      k++;
    end
    start = 1'b0;
    check("a4_first_freq",    f2,     13636);
    check("a4_index_cycles",  a4,     20);
    check("a4_sonando_cycles", a4_son, (G == 2) ? 18 : 20);
    check("b4_freq_cycles",   b4,     (G == 2) ? 8 : 10);
    check("fin_pulses",       fin_n,  1);
    check("fin_cycle",        k_fin,  45);
    check("busy_fall_cycle",  k_idle, 46);
    repeat (3) tick();

    // Looping: A4 returns every 44 cycles, never a fin pulse.
    loop_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    onsets = 0; fin_n = 0; busy_low = 0; prev_f = 0;
    for (int c = 1; c <= 140; c++) begin
      if (freq == 16'd13636 && prev_f != 13636) onsets++;
      prev_f = int'(freq);
      if (fin) fin_n++;
      if (!busy) busy_low++;
      tick();
    end
    check("loop_a4_onsets",  onsets,   4);
    check("loop_fin_pulses", fin_n,    0);
    check("loop_busy_low",   busy_low, 0);
    check("mid_play_sonando", int'(sonando), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_outputs", int'({indice_nota, freq, sonando, fin}), 0);
    check("stop_busy",    int'(busy), 0);
    loop_en = 1'b0;
    repeat (3) tick();

    // rst 20 cycles into the A4 slot (GAP when built, PLAY otherwise) with start also high.
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("pre_rst_index",   int'(indice_nota), 10);
    check("pre_rst_sonando", int'(sonando), (G > 0) ? 0 : 1);
    rst = 1'b1; start = 1'b1; tick();
    check("rst_mid_outputs", int'({indice_nota, freq, sonando, fin}), 0);
    check("rst_mid_busy",    int'(busy), 0);
    rst = 1'b0; start = 1'b0; tick();
    check("after_rst_busy",  int'(busy), 0);

    // start and stop together in IDLE: stays idle.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("start_stop_busy", int'(busy), 0);
    tick();
    check("start_stop_busy_later", int'(busy), 0);
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/secuenciador_melodia.md
SECUENCIADOR_MELODIA -- requirements
Module: secuenciador_melodia

Interface
REQ-001 SHALL have parameter TEMPO_TICKS, default 1_500_000, clk cycles per duration unit (125 ms at 12 MHz).
REQ-002 SHALL have parameter GAP_TICKS, default 120_000, silent articulation cycles at the end of each note slot; requires GAP_TICKS < TEMPO_TICKS.
REQ-003 SHALL have parameter N_PASOS, default 32, melody ROM depth; address width is clog2(N_PASOS).
REQ-004 clk  input  1  system clock, 12 MHz; one clock domain, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins playback from step 0.
REQ-007 stop  input  1  one-cycle pulse; aborts playback.
REQ-008 loop_en  input  1  level; sampled at the end marker, selects restart versus finish.
REQ-009 indice_nota  output  5  current note index to the tone generator; 0 means rest.
REQ-010 freq  output  16  tone-generator half-period divisor in clk cycles; 0 means silent.
REQ-011 sonando  output  1  gate; high while a non-rest note must sound.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 fin  output  1  one-cycle pulse when a non-looping melody completes.

Function
REQ-014 ROM entry SHALL be 8 bits: {nota[4:0], dur[2:0]}; dur = 0 is the end marker; ROM read latency is 1 cycle (registered).
REQ-015 FSM states SHALL be IDLE, LOAD, PLAY, GAP, DONE.
REQ-016 IDLE: on start (with stop low), addr <= 0 and go to LOAD the next cycle; otherwise remain.
REQ-017 LOAD (1 cycle): latch ROM word. If dur = 0: go to LOAD with addr <= 0 when loop_en = 1, else go to DONE. If dur != 0: drive indice_nota and freq, and go to PLAY.
REQ-018 PLAY SHALL last dur*TEMPO_TICKS - GAP_TICKS cycles, then go to GAP; GAP SHALL last GAP_TICKS cycles with sonando = 0 and freq = 0, then go to LOAD with addr + 1.
REQ-019 Slot length from LOAD to the next LOAD SHALL be 1 + dur*TEMPO_TICKS cycles.
REQ-020 Rest (nota = 0): sonando = 0 and freq = 0 for the whole slot; timing is identical to a note.
REQ-021 freq SHALL equal 12_000_000 / (2*f_nota), taken from a constant table indexed by nota; index 10 = A4 = 13636, index 12 = B4 = 12148, unused indices = 0.
REQ-022 addr SHALL wrap to 0 after N_PASOS-1 without a marker, then continue as if a marker was reached with loop_en = 1.
REQ-023 DONE (1 cycle): fin = 1, then go to IDLE.
REQ-024 stop in any state SHALL force IDLE on the next cycle with outputs at reset values; stop wins over a simultaneous start.
REQ-025 start while busy = 1 SHALL be ignored.
REQ-026 The tempo counter SHALL be wide enough for 7*TEMPO_TICKS with no overflow.

Reset
REQ-027 On rst SHALL clear: state = IDLE, addr = 0, counter = 0; outputs indice_nota = 0, freq = 0, sonando = 0, busy = 0, fin = 0.
REQ-028 rst mid-playback SHALL abort identically to stop, and takes priority over start and stop.

Configuration
REQ-029 Macro SECUENCIADOR_GAP_EN: when defined, GAP behaves per REQ-018.
REQ-030 Without SECUENCIADOR_GAP_EN: the GAP state is not built; PLAY lasts dur*TEMPO_TICKS cycles (legato), and slot length per REQ-019 is unchanged.

Structure
REQ-031 Package caja_musical_pkg SHALL hold the FSM state enum, the note-to-divisor constant table, and the ROM field widths.
REQ-032 Sub-module rom_melodia SHALL hold the registered melody ROM; the FSM and counters stay in secuenciador_melodia.

Verification (TEMPO_TICKS=10, GAP_TICKS=2, ROM = {10,2},{0,1},{12,1},{0,0})
REQ-033 start at t0 -> LOAD at t0+1; freq = 13636, sonando = 1 for 18 cycles, 0 for 2 cycles; next LOAD at t0+22.
REQ-034 Full melody with loop_en = 0 -> rest slot with sonando = 0 and freq = 0; B4 freq = 12148 for 8 cycles; a single fin pulse; busy falls the cycle after fin.
REQ-035 loop_en = 1 -> after the marker, freq = 13636 again with no fin pulse; verify over 3 loops.
REQ-036 stop mid-PLAY, and rst mid-GAP -> all outputs 0 next cycle, busy = 0; start and stop in the same cycle in IDLE -> remains IDLE.
REQ-037 Build without SECUENCIADOR_GAP_EN -> A4 sonando high for 20 consecutive cycles; slot length still 21 cycles.
